// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: arbitrates EXU/LSU results into an in-order FIFO feeding the RF write port.
// Debug writes take the port ahead of the queue. A pending bitmap tracks queued destinations.
module rf_writeback_queue #(
   parameter int ADDR_WIDTH = 5,
   parameter int WORD_LEN   = 32,
   parameter int DEPTH      = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_exu_valid,
   output logic                      o_exu_ready,
   input  logic [ADDR_WIDTH-1:0]     i_exu_rd,
   input  logic [WORD_LEN-1:0]       i_exu_data,
   input  logic                      i_lsu_valid,
   output logic                      o_lsu_ready,
   input  logic [ADDR_WIDTH-1:0]     i_lsu_rd,
   input  logic [WORD_LEN-1:0]       i_lsu_data,
   input  logic                      i_dbg_wen,
   input  logic [ADDR_WIDTH-1:0]     i_dbg_waddr,
   input  logic [WORD_LEN-1:0]       i_dbg_wdata,
   output logic                      o_rf_wen,
   output logic [ADDR_WIDTH-1:0]     o_rf_waddr,
   output logic [WORD_LEN-1:0]       o_rf_wdata,
   output logic [2**ADDR_WIDTH-1:0]  o_pending,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_full,
   output logic                      o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int NR = 2**ADDR_WIDTH;
   logic [ADDR_WIDTH-1:0] r_rd [DEPTH];
   logic [WORD_LEN-1:0]   r_data [DEPTH];
   logic [DEPTH-1:0]      r_vld;
   logic [AW-1:0]         r_wptr, r_rptr;
   logic [AW:0]           r_count;
   logic                  r_rr;
   logic [NR-1:0]         r_pending;
   logic                  w_space, w_conf, w_take_exu, w_take_lsu, w_enq, w_deq;
   logic [ADDR_WIDTH-1:0] w_rd;
   logic [WORD_LEN-1:0]   w_dat;
   logic [DEPTH-1:0]      w_vld_nxt;
   logic [NR-1:0]         w_pend_nxt;
   assign w_space     = r_count < (AW+1)'(DEPTH);
   assign w_conf      = i_exu_valid & i_lsu_valid & w_space;
   // r_rr == 0 means EXU wins the next conflict
   assign o_exu_ready = w_space & (~i_lsu_valid | ~r_rr);
   assign o_lsu_ready = w_space & (~i_exu_valid | r_rr);
   assign w_take_exu  = i_exu_valid & o_exu_ready;
   assign w_take_lsu  = i_lsu_valid & o_lsu_ready;
   assign w_rd        = w_take_lsu ? i_lsu_rd : i_exu_rd;
   assign w_dat       = w_take_lsu ? i_lsu_data : i_exu_data;
   assign w_enq       = (w_take_exu | w_take_lsu) & (|w_rd);
   assign w_deq       = ~i_dbg_wen & ~o_empty;
   assign o_count     = r_count;
   assign o_full      = ~w_space;
   assign o_empty     = r_count == '0;
   assign o_pending   = r_pending;
   assign o_rf_wen    = i_dbg_wen | ~o_empty;
   assign o_rf_waddr  = i_dbg_wen ? i_dbg_waddr : o_empty ? '0 : r_rd[r_rptr];
   assign o_rf_wdata  = i_dbg_wen ? i_dbg_wdata : o_empty ? '0 : r_data[r_rptr];
   always_comb begin
      w_vld_nxt  = r_vld;
      w_pend_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_deq && r_rptr == AW'(i)) w_vld_nxt[i] = 1'b0;
         if (w_enq && r_wptr == AW'(i)) w_vld_nxt[i] = 1'b1;
         if (w_vld_nxt[i]) w_pend_nxt[(w_enq && r_wptr == AW'(i)) ? w_rd : r_rd[i]] = 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_vld     <= '0;
         r_rr      <= 1'b0;
         r_pending <= '0;
      end else begin
         if (w_enq) begin
            r_rd[r_wptr]   <= w_rd;
            r_data[r_wptr] <= w_dat;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_deq) r_rptr <= r_rptr + 1'b1;
         if (w_conf) r_rr <= ~r_rr;
         r_count   <= r_count + {{AW{1'b0}}, w_enq} - {{AW{1'b0}}, w_deq};
         r_vld     <= w_vld_nxt;
         r_pending <= w_pend_nxt;
      end
   end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed stimulus with a queue-level reference model checked every cycle.
module tb_rf_writeback_queue;
   logic        clk = 1'b0, reset = 1'b0;
   logic        exu_valid = 1'b0, lsu_valid = 1'b0, dbg_wen = 1'b0;
   logic [4:0]  exu_rd = '0, lsu_rd = '0, dbg_waddr = '0;
   logic [31:0] exu_data = '0, lsu_data = '0, dbg_wdata = '0;
   logic        exu_ready, lsu_ready, rf_wen, full, empty;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, pending;
   logic [2:0]  count;
   int          n_pass = 0, n_tot = 0;
   typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
   ent_t        q[$];
   ent_t        e;
   bit          mrr = 1'b0, armed = 1'b0, sp, eg, lg;
   logic [31:0] mp;
   rf_writeback_queue dut (
      .i_clk(clk), .i_reset(reset),
      .i_exu_valid(exu_valid), .o_exu_ready(exu_ready), .i_exu_rd(exu_rd), .i_exu_data(exu_data),
      .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
      .i_dbg_wen(dbg_wen), .i_dbg_waddr(dbg_waddr), .i_dbg_wdata(dbg_wdata),
      .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
      .o_pending(pending), .o_count(count), .o_full(full), .o_empty(empty)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask
   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         mrr   = 1'b0;
         armed = 1'b1;
      end else if (armed) begin
         sp = q.size() < 4;
         eg = exu_valid && sp && (!lsu_valid || !mrr);
         lg = lsu_valid && sp && (!exu_valid || mrr);
         if (exu_valid && lsu_valid && sp) mrr = !mrr;
         if (!dbg_wen && q.size() > 0) e = q.pop_front();
         if (eg && exu_rd != 0) q.push_back('{exu_rd, exu_data});
         else if (lg && lsu_rd != 0) q.push_back('{lsu_rd, lsu_data});
      end
   end
   always @(negedge clk) begin
      if (armed) begin
         sp = q.size() < 4;
         mp = '0;
         foreach (q[i]) mp[q[i].rd] = 1'b1;
         chk("m_exu_ready", exu_ready, sp && (!lsu_valid || !mrr));
         chk("m_lsu_ready", lsu_ready, sp && (!exu_valid || mrr));
         chk("m_rf_wen", rf_wen, dbg_wen || q.size() > 0);
         chk("m_rf_waddr", rf_waddr, dbg_wen ? dbg_waddr : q.size() > 0 ? q[0].rd : 5'd0);
         chk("m_rf_wdata", rf_wdata, dbg_wen ? dbg_wdata : q.size() > 0 ? q[0].d : 32'd0);
         chk("m_pending", pending, mp);
         chk("m_count", count, q.size());
         chk("m_full", full, q.size() == 4);
         chk("m_empty", empty, q.size() == 0);
      end
   end
   task automatic go();
      @(posedge clk);
      #1;
   endtask
   task automatic smp();
      @(negedge clk);
   endtask
   initial begin
      exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'd1;
      go; go;
      smp;
      chk("rst_wen", rf_wen, 0);
      chk("rst_count", count, 0);
      chk("rst_pending", pending, 0);
      chk("rst_empty", empty, 1);
      go;
      reset = 1'b1;
      smp;
      chk("rel_ready", exu_ready, 1);
      go;
      exu_valid = 1'b0;
      smp;
      chk("rel_wen", rf_wen, 1);
      chk("rel_waddr", rf_waddr, 3);
      go;
      exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
      smp;
      chk("single_ready", exu_ready, 1);
      go;
      exu_valid = 1'b0;
      smp;
      chk("single_wen", rf_wen, 1);
      chk("single_waddr", rf_waddr, 5);
      chk("single_wdata", rf_wdata, 32'hDEADBEEF);
      chk("single_pend", pending, 32'h20);
      go;
      smp;
      chk("single_pend_clr", pending, 0);
      chk("single_wen_off", rf_wen, 0);
      go;
      exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'd11;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'd22;
      smp;
      chk("conf1_exu", exu_ready, 1);
      chk("conf1_lsu", lsu_ready, 0);
      go;
      smp;
      chk("conf2_exu", exu_ready, 0);
      chk("conf2_lsu", lsu_ready, 1);
      chk("conf2_waddr", rf_waddr, 1);
      go;
      exu_valid = 1'b0; lsu_valid = 1'b0;
      smp;
      chk("conf3_waddr", rf_waddr, 2);
      chk("conf3_wdata", rf_wdata, 22);
      go;
      smp;
      chk("conf_empty", empty, 1);
      go;
      dbg_wen = 1'b1; dbg_waddr = 5'd9; dbg_wdata = 32'h99;
      for (int i = 0; i < 4; i++) begin
         exu_valid = 1'b1; exu_rd = 5'(10 + i); exu_data = 32'(100 + i);
         smp;
         chk("full_acc", exu_ready, 1);
         go;
      end
      exu_rd = 5'd14; exu_data = 32'd104;
      smp;
      chk("full_flag", full, 1);
      chk("full_count", count, 4);
      chk("full_ready", exu_ready, 0);
      chk("full_dbg", rf_waddr, 9);
      chk("full_pend", pending, 32'h3C00);
      go;
      dbg_wen = 1'b0;
      smp;
      chk("drain_ready0", exu_ready, 0);
      chk("drain_head", rf_waddr, 10);
      chk("drain_data", rf_wdata, 100);
      go;
      smp;
      chk("drain_ready1", exu_ready, 1);
      chk("drain_11", rf_waddr, 11);
      go;
      exu_valid = 1'b0;
      for (int j = 12; j <= 14; j++) begin
         smp;
         chk("drain_order", rf_waddr, j);
         go;
      end
      smp;
      chk("drain_empty", empty, 1);
      go;
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'd7;
      smp;
      chk("x0_ready", lsu_ready, 1);
      go;
      lsu_valid = 1'b0;
      smp;
      chk("x0_count", count, 0);
      chk("x0_wen", rf_wen, 0);
      go;
      dbg_wen = 1'b1; dbg_waddr = 5'd4; dbg_wdata = 32'h44;
      for (int i = 0; i < 3; i++) begin
         exu_valid = 1'b1; exu_rd = 5'(20 + i); exu_data = 32'(200 + i);
         go;
      end
      exu_valid = 1'b0;
      smp;
      chk("mid_count", count, 3);
      chk("mid_pend", pending, 32'h0070_0000);
      go;
      reset = 1'b0;
      go;
      reset = 1'b1; dbg_wen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp;
         chk("mid_wen", rf_wen, 0);
         chk("mid_cnt0", count, 0);
         go;
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
